// File: rtl/crack_scheduler_pkg.sv
// Shared types and helpers for the RC4 key-space scheduler.
package crack_pkg;

  localparam int unsigned KEY_W_DEF = 24;
  localparam int unsigned N_CH_MAX  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FOUND = 2'd2
  } sched_state_e;

  function automatic logic [3:0] popcount(input logic [N_CH_MAX-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < int'(N_CH_MAX); i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/crack_scheduler_ch_pick.sv
// Lowest-index first-one finder: one-hot grant of the lowest set request bit.
module ch_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant_c,
  output logic         valid_c
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant_c = req & (~req + N'(1));
  assign valid_c = |req;

endmodule

// File: rtl/crack_scheduler.sv
// Fans a key range out to N_CH crack channels, collects verdicts and reports
// the first key found (lowest channel wins ties) or exhaustion of the range.
module crack_scheduler
  import crack_pkg::*;
#(
  parameter int unsigned      N_CH      = 2,
  parameter int unsigned      KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter logic [KEY_W-1:0] KEY_END   = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  rdy,
  output logic                  done,
  output logic                  key_valid,
  output logic [KEY_W-1:0]      key,
  output logic [KEY_W:0]        keys_tried,
  input  logic [N_CH-1:0]       ch_rdy,
  output logic [N_CH-1:0]       ch_en,
  output logic [N_CH*KEY_W-1:0] ch_key,
  input  logic [N_CH-1:0]       ch_done,
  input  logic [N_CH-1:0]       ch_found,
  output logic                  ch_abort
);

  localparam int unsigned    KT_W  = KEY_W + 1;
  localparam logic [KEY_W:0] END_X = {1'b0, KEY_END};
  localparam logic [KEY_W:0] BEG_X = {1'b0, KEY_START};

  sched_state_e             state_q, state_d;
  logic                     rdy_q, rdy_d;
  logic                     done_q, done_d;
  logic                     key_valid_q, key_valid_d;
  logic [KEY_W-1:0]         key_q, key_d;
  logic [KEY_W:0]           keys_tried_q, keys_tried_d;
  logic [N_CH-1:0]          ch_en_q, ch_en_d;
  logic [N_CH*KEY_W-1:0]    ch_key_q, ch_key_d;
  logic                     ch_abort_q, ch_abort_d;
  logic [KEY_W:0]           next_key_q, next_key_d;
  logic [N_CH-1:0]          busy_q, busy_d;

  logic [N_CH-1:0] avail_c, disp_grant_c, found_req_c, found_grant_c;
  logic            disp_valid_c, found_valid_c, keys_left_c;

  // A channel reporting this cycle is not redispatched until the next one.
  assign avail_c     = ch_rdy & ~busy_q & ~ch_done;
  assign found_req_c = ch_done & ch_found;
  assign keys_left_c = (next_key_q <= END_X);

  ch_pick #(.N(N_CH)) u_disp_pick (
    .req     (avail_c),
    .grant_c (disp_grant_c),
    .valid_c (disp_valid_c)
  );

  ch_pick #(.N(N_CH)) u_found_pick (
    .req     (found_req_c),
    .grant_c (found_grant_c),
    .valid_c (found_valid_c)
  );

  always_comb begin
    state_d      = state_q;
    rdy_d        = rdy_q;
    done_d       = done_q;
    key_valid_d  = key_valid_q;
    key_d        = key_q;
    keys_tried_d = keys_tried_q;
    ch_en_d      = '0;
    ch_key_d     = ch_key_q;
    ch_abort_d   = 1'b0;
    next_key_d   = next_key_q;
    busy_d       = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (en && rdy_q) begin
          state_d      = ST_RUN;
          rdy_d        = 1'b0;
          done_d       = 1'b0;
          key_valid_d  = 1'b0;
          key_d        = '0;
          keys_tried_d = '0;
          next_key_d   = BEG_X;
          busy_d       = '0;
        end
      end

      ST_RUN: begin
        keys_tried_d = keys_tried_q + KT_W'(popcount(N_CH_MAX'(ch_done)));
        busy_d       = busy_q & ~ch_done;
        if (found_valid_c) begin
          state_d    = ST_FOUND;
          ch_abort_d = 1'b1;
          for (int i = 0; i < int'(N_CH); i++) begin
            if (found_grant_c[i]) key_d = ch_key_q[i*KEY_W +: KEY_W];
          end
        end else if (keys_left_c) begin
          if (disp_valid_c) begin
            ch_en_d    = disp_grant_c;
            busy_d     = busy_d | disp_grant_c;
            next_key_d = next_key_q + KT_W'(1);
            for (int i = 0; i < int'(N_CH); i++) begin
              if (disp_grant_c[i]) ch_key_d[i*KEY_W +: KEY_W] = next_key_q[KEY_W-1:0];
            end
          end
        end else if (busy_q == '0) begin
          state_d     = ST_IDLE;
          rdy_d       = 1'b1;
          done_d      = 1'b1;
          key_valid_d = 1'b0;
          key_d       = '0;
        end
      end

      ST_FOUND: begin
        state_d     = ST_IDLE;
        busy_d      = '0;
        rdy_d       = 1'b1;
        done_d      = 1'b1;
        key_valid_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rdy_q        <= 1'b1;
      done_q       <= 1'b0;
      key_valid_q  <= 1'b0;
      key_q        <= '0;
      keys_tried_q <= '0;
      ch_en_q      <= '0;
      ch_key_q     <= '0;
      ch_abort_q   <= 1'b0;
      next_key_q   <= BEG_X;
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      done_q       <= done_d;
      key_valid_q  <= key_valid_d;
      key_q        <= key_d;
      keys_tried_q <= keys_tried_d;
      ch_en_q      <= ch_en_d;
      ch_key_q     <= ch_key_d;
      ch_abort_q   <= ch_abort_d;
      next_key_q   <= next_key_d;
      busy_q       <= busy_d;
    end
  end

  assign rdy        = rdy_q;
  assign done       = done_q;
  assign key_valid  = key_valid_q;
  assign key        = key_q;
  assign keys_tried = keys_tried_q;
  assign ch_en      = ch_en_q;
  assign ch_key     = ch_key_q;
  assign ch_abort   = ch_abort_q;

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench: three scheduler instances driven by stub crack channels,
// dispatched keys checked against a queue of expected keys.
module tb_crack_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] en_v;

  wire  [2:0] rdy_v, done_v, kv_v, ab_v;
  wire  [3:0] key_o [3];
  wire  [4:0] kt_o  [3];
  wire  [1:0] a_en, c_en;
  wire  [3:0] b_en;
  wire  [7:0] a_key, c_key;
  wire  [15:0] b_key;

  // Flattened channel slots: dut d channel c lives at index d*4+c.
  wire  [11:0] en_all  = {2'b00, c_en, b_en, 2'b00, a_en};
  wire  [47:0] key_all = {8'h00, c_key, b_key, 8'h00, a_key};

  logic [11:0] st_busy, st_done, st_found;
  wire  [11:0] st_rdy = ~st_busy;
  logic [3:0]  st_key [12];
  int          st_cnt [12];

  int          lat;
  logic [4:0]  tgt0, tgt1, fast_key;

  int          sel;
  int          checks;
  int          errors;
  int          n_abort;
  logic [3:0]  exp_q [$];

  crack_scheduler #(.N_CH(2), .KEY_W(4), .KEY_START(4'd0), .KEY_END(4'd15)) u_a (
    .clk(clk), .rst(rst), .en(en_v[0]), .rdy(rdy_v[0]), .done(done_v[0]),
    .key_valid(kv_v[0]), .key(key_o[0]), .keys_tried(kt_o[0]),
    .ch_rdy(st_rdy[1:0]), .ch_en(a_en), .ch_key(a_key),
    .ch_done(st_done[1:0]), .ch_found(st_found[1:0]), .ch_abort(ab_v[0]));

  crack_scheduler #(.N_CH(4), .KEY_W(4), .KEY_START(4'd0), .KEY_END(4'd15)) u_b (
    .clk(clk), .rst(rst), .en(en_v[1]), .rdy(rdy_v[1]), .done(done_v[1]),
    .key_valid(kv_v[1]), .key(key_o[1]), .keys_tried(kt_o[1]),
    .ch_rdy(st_rdy[7:4]), .ch_en(b_en), .ch_key(b_key),
    .ch_done(st_done[7:4]), .ch_found(st_found[7:4]), .ch_abort(ab_v[1]));

  crack_scheduler #(.N_CH(2), .KEY_W(4), .KEY_START(4'd14), .KEY_END(4'd15)) u_c (
    .clk(clk), .rst(rst), .en(en_v[2]), .rdy(rdy_v[2]), .done(done_v[2]),
    .key_valid(kv_v[2]), .key(key_o[2]), .keys_tried(kt_o[2]),
    .ch_rdy(st_rdy[9:8]), .ch_en(c_en), .ch_key(c_key),
    .ch_done(st_done[9:8]), .ch_found(st_found[9:8]), .ch_abort(ab_v[2]));

  // Stub channels: fixed latency (one shorter for fast_key), found on target match.
  always @(posedge clk) begin
    for (int j = 0; j < 12; j++) begin
      st_done[j]  <= 1'b0;
      st_found[j] <= 1'b0;
      if (rst || ab_v[j/4]) begin
        st_busy[j] <= 1'b0;
      end else if (en_all[j]) begin
        st_busy[j] <= 1'b1;
        st_key[j]  <= key_all[j*4 +: 4];
        st_cnt[j]  <= ({1'b0, key_all[j*4 +: 4]} == fast_key) ? lat - 2 : lat - 1;
      end else if (st_busy[j]) begin
        if (st_cnt[j] == 0) begin
          st_done[j]  <= 1'b1;
          st_busy[j]  <= 1'b0;
          st_found[j] <= ({1'b0, st_key[j]} == tgt0) || ({1'b0, st_key[j]} == tgt1);
        end else begin
          st_cnt[j] <= st_cnt[j] - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle, then score any dispatch and abort of the selected instance.
  task automatic step();
    @(negedge clk);
    for (int j = 0; j < 12; j++) begin
      if (j / 4 == sel && en_all[j] === 1'b1) begin
        chk("dispatch_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("dispatch_key", 32'(key_all[j*4 +: 4]), 32'(exp_q.pop_front()));
      end
    end
    if (ab_v[sel] === 1'b1) n_abort++;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) exp_q.push_back(4'(k));
  endtask

  task automatic start(input int d);
    sel     = d;
    n_abort = 0;
    chk("rdy_before_start", 32'(rdy_v[d]), 32'd1);
    en_v[d] = 1'b1;
    step();
    en_v[d] = 1'b0;
    chk("rdy_low_after_accept", 32'(rdy_v[d]), 32'd0);
    chk("done_clear_after_accept", 32'(done_v[d]), 32'd0);
    chk("key_valid_clear_after_accept", 32'(kv_v[d]), 32'd0);
    chk("keys_tried_zero_after_accept", 32'(kt_o[d]), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_v[sel] !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("done_within_budget", 32'(done_v[sel]), 32'd1);
  endtask

  initial begin
    int n;
    checks   = 0;
    errors   = 0;
    n_abort  = 0;
    sel      = 0;
    rst      = 1'b1;
    en_v     = '0;
    lat      = 4;
    tgt0     = 5'h10;
    tgt1     = 5'h10;
    fast_key = 5'h1f;
    step();
    step();
    rst = 1'b0;
    step();

    chk("reset_rdy", 32'(rdy_v[0]), 32'd1);
    chk("reset_done", 32'(done_v[0]), 32'd0);
    chk("reset_key_valid", 32'(kv_v[0]), 32'd0);
    chk("reset_key", 32'(key_o[0]), 32'd0);
    chk("reset_keys_tried", 32'(kt_o[0]), 32'd0);
    chk("reset_ch_en", 32'(en_all), 32'd0);
    chk("reset_ch_key", 32'(a_key), 32'd0);
    chk("reset_ch_abort", 32'(ab_v), 32'd0);

    // Target 5 on two channels, with an en pulse during the run.
    tgt0 = 5'd5;
    push_range(0, 5);
    start(0);
    repeat (3) step();
    en_v[0] = 1'b1;
    step();
    en_v[0] = 1'b0;
    chk("en_in_run_rdy", 32'(rdy_v[0]), 32'd0);
    chk("en_in_run_done", 32'(done_v[0]), 32'd0);
    wait_done(400);
    chk("t5_key_valid", 32'(kv_v[0]), 32'd1);
    chk("t5_key", 32'(key_o[0]), 32'd5);
    chk("t5_keys_tried", 32'(kt_o[0]), 32'd6);
    chk("t5_rdy", 32'(rdy_v[0]), 32'd1);
    chk("t5_abort_pulses", 32'(n_abort), 32'd1);
    chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    chk("t5_done_held", 32'(done_v[0]), 32'd1);
    chk("t5_key_held", 32'(key_o[0]), 32'd5);

    // Targets 6 (ch0) and 7 (ch1) report in the same cycle; ch0 wins.
    tgt0     = 5'd6;
    tgt1     = 5'd7;
    fast_key = 5'd7;
    push_range(0, 7);
    start(0);
    wait_done(400);
    chk("tie_key_valid", 32'(kv_v[0]), 32'd1);
    chk("tie_key", 32'(key_o[0]), 32'd6);
    chk("tie_keys_tried", 32'(kt_o[0]), 32'd8);
    chk("tie_abort_pulses", 32'(n_abort), 32'd1);
    chk("tie_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a search, then restart from KEY_START.
    tgt0     = 5'h10;
    tgt1     = 5'h10;
    fast_key = 5'h1f;
    push_range(0, 15);
    start(0);
    n = 0;
    while (kt_o[0] !== 5'd3 && n < 300) begin
      step();
      n++;
    end
    chk("mid_run_reached_three", 32'(kt_o[0]), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rdy", 32'(rdy_v[0]), 32'd1);
    chk("mid_rst_done", 32'(done_v[0]), 32'd0);
    chk("mid_rst_keys_tried", 32'(kt_o[0]), 32'd0);
    chk("mid_rst_ch_en", 32'(a_en), 32'd0);
    exp_q.delete();
    step();
    push_range(0, 15);
    start(0);
    wait_done(600);
    chk("restart_key_valid", 32'(kv_v[0]), 32'd0);
    chk("restart_key", 32'(key_o[0]), 32'd0);
    chk("restart_keys_tried", 32'(kt_o[0]), 32'd16);
    chk("restart_no_abort", 32'(n_abort), 32'd0);
    chk("restart_queue_drained", 32'(exp_q.size()), 32'd0);

    // Four channels, no target: full range exhausted.
    push_range(0, 15);
    start(1);
    wait_done(600);
    chk("n4_key_valid", 32'(kv_v[1]), 32'd0);
    chk("n4_key", 32'(key_o[1]), 32'd0);
    chk("n4_keys_tried", 32'(kt_o[1]), 32'd16);
    chk("n4_no_abort", 32'(n_abort), 32'd0);
    chk("n4_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("n4_rdy", 32'(rdy_v[1]), 32'd1);

    // Range 14..15 at the top of the key space must not wrap to 0.
    push_range(14, 15);
    start(2);
    wait_done(400);
    chk("top_key_valid", 32'(kv_v[2]), 32'd0);
    chk("top_keys_tried", 32'(kt_o[2]), 32'd2);
    repeat (6) step();
    chk("top_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("top_idle_ch_en", 32'(c_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
